// File: rtl/dmem_pkg.sv
// Shared types and default sizing for the M-stage data-memory responder.
package dmem_pkg;

   localparam int DMEM_AW     = 6;
   localparam int DMEM_WB_DEP = 4;
   localparam int DMEM_WR_LAT = 3;

   typedef enum logic {
      IDLE  = 1'b0,
      WRITE = 1'b1
   } dmem_st_t;

   typedef struct packed {
      logic [DMEM_AW-1:0] idx;
      logic [31:0]        data;
   } wb_entry_t;

   // Width of a down-counter that must hold lat-1; never narrower than one bit.
   function automatic int lat_width(input int lat);
      return (lat > 1) ? $clog2(lat) : 1;
   endfunction

endpackage

// File: rtl/wbuf_fifo.sv
// Circular write-buffer FIFO. Besides push/pop it exposes every slot in age
// order (index 0 = youngest) with a valid mask, so the load path can search it.
module wbuf_fifo
   import dmem_pkg::*;
#(
   parameter int  DEP     = DMEM_WB_DEP,
   parameter type entry_t = wb_entry_t,
   localparam int PW      = $clog2(DEP)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 push,
   input  entry_t               push_entry,
   input  logic                 pop,
   output logic                 full,
   output logic                 empty,
   output logic [PW:0]          count,
   output entry_t               head_entry,
   output entry_t [DEP-1:0]     age_entries,
   output logic   [DEP-1:0]     age_valid
);

   entry_t [DEP-1:0] slots;
   logic   [PW-1:0]  head;
   logic   [PW-1:0]  tail;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (PW+1)'(DEP));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   // Pointer and occupancy bookkeeping; pointers wrap naturally at DEP.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values, independent of statement order.
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (do_push) tail <= tail + PW'(1);
         if (do_pop)  head <= head + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Slot storage written at the tail on an accepted push.
   always_ff @(posedge clk) begin
      // NOTE: storage is deliberately not reset; the valid mask derived from
      // count decides which slots mean anything.
      if (do_push) slots[tail] <= push_entry;
   end

   assign head_entry = slots[head];

   // Age-ordered view: slot tail-1 is the youngest, valid while i < count.
   for (genvar i = 0; i < DEP; i++) begin : g_age
      assign age_entries[i] = slots[tail - PW'(i + 1)];
      assign age_valid[i]   = ((PW+1)'(i) < count);
   end

endmodule

// File: rtl/dmem_wbuf_responder.sv
// M-stage data memory: same-cycle loads with store forwarding from a posted
// write buffer, which drains into a slow word array one write per WR_LAT cycles.
module dmem_wbuf_responder
   import dmem_pkg::*;
#(
   parameter int AW     = DMEM_AW,
   parameter int WB_DEP = DMEM_WB_DEP,
   parameter int WR_LAT = DMEM_WR_LAT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemWriteM,
   input  logic [31:0] ALUOutM,
   input  logic [31:0] WriteDataM,
   output logic [31:0] ReadDataM,
   output logic        MemStallM,
   output logic        wb_empty
);

   localparam int PW = $clog2(WB_DEP);
   localparam int LW = lat_width(WR_LAT);

   // Same layout as wb_entry_t, sized by this instance's AW.
   typedef struct packed {
      logic [AW-1:0] idx;
      logic [31:0]   data;
   } entry_t;

   dmem_st_t                state;
   logic [LW-1:0]           lat;
   logic [31:0]             mem [2**AW];
   logic [AW-1:0]           rd_idx;
   entry_t                  push_entry;
   entry_t                  head_entry;
   entry_t [WB_DEP-1:0]     age_entries;
   logic   [WB_DEP-1:0]     age_valid;
   logic [PW:0]             fifo_count;
   logic                    fifo_full;
   logic                    fifo_empty;
   logic                    drain_done;
   logic                    unused_addr_bits;

   assign rd_idx           = ALUOutM[AW+1:2];
   assign unused_addr_bits = ^{ALUOutM[31:AW+2], ALUOutM[1:0]};
   assign push_entry       = '{idx: rd_idx, data: WriteDataM};
   assign drain_done       = (state == WRITE) && (lat == '0);
   assign MemStallM        = MemWriteM & fifo_full;
   assign wb_empty         = fifo_empty & (state == IDLE);

   wbuf_fifo #(
      .DEP     (WB_DEP),
      .entry_t (entry_t)
   ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .push        (MemWriteM),
      .push_entry  (push_entry),
      .pop         (drain_done),
      .full        (fifo_full),
      .empty       (fifo_empty),
      .count       (fifo_count),
      .head_entry  (head_entry),
      .age_entries (age_entries),
      .age_valid   (age_valid)
   );

   // Drain FSM: hold each head write for WR_LAT cycles, then retire it.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         lat   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (fifo_count != '0) begin
                  state <= WRITE;
                  lat   <= LW'(WR_LAT - 1);
               end
            end
            WRITE: begin
               if (lat != '0) begin
                  lat <= lat - LW'(1);
               end else if (fifo_count != (PW+1)'(1)) begin
                  lat <= LW'(WR_LAT - 1);
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Word array; a reset landing on the final latency cycle discards that write.
   always_ff @(posedge clk) begin
      if (drain_done && !reset) mem[head_entry.idx] <= head_entry.data;
   end

   // Load path: array word, overridden by matching entries from oldest to youngest.
   always_comb begin
      // NOTE: the unconditional default before the search keeps this purely
      // combinational; a missing default would infer a latch.
      ReadDataM = mem[rd_idx];
      for (int i = WB_DEP - 1; i >= 0; i--) begin
         if (age_valid[i] && (age_entries[i].idx == rd_idx)) ReadDataM = age_entries[i].data;
      end
   end

endmodule

// File: tb/tb_dmem_wbuf_responder.sv
// Directed bench for dmem_wbuf_responder (AW=6, WB_DEP=4, WR_LAT=3).
module tb_dmem_wbuf_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic        MemWriteM;
   logic [31:0] ALUOutM;
   logic [31:0] WriteDataM;
   logic [31:0] ReadDataM;
   logic        MemStallM;
   logic        wb_empty;

   int n_asserts = 0;
   int n_fail    = 0;

   dmem_wbuf_responder dut (
      .clk        (clk),
      .reset      (reset),
      .MemWriteM  (MemWriteM),
      .ALUOutM    (ALUOutM),
      .WriteDataM (WriteDataM),
      .ReadDataM  (ReadDataM),
      .MemStallM  (MemStallM),
      .wb_empty   (wb_empty)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic store(input logic [31:0] addr, input logic [31:0] data);
      MemWriteM  = 1'b1;
      ALUOutM    = addr;
      WriteDataM = data;
      tick();
      MemWriteM  = 1'b0;
   endtask

   task automatic load(input logic [31:0] addr);
      MemWriteM = 1'b0;
      ALUOutM   = addr;
      #1;
   endtask

   task automatic wait_empty(input string tag, input int budget);
      int n = 0;
      while (wb_empty !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
      check(tag, 32'(wb_empty), 32'h1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset      = 1'b1;
      MemWriteM  = 1'b0;
      ALUOutM    = '0;
      WriteDataM = '0;
      tick();
      tick();
      reset = 1'b0;

      // Preload array words through the buffer, then reset (array survives reset).
      store(32'h10, 32'hA5A5_0004);
      store(32'h20, 32'h1111_1111);
      store(32'h60, 32'h3333_3333);
      wait_empty("preload_drain", 40);
      reset = 1'b1;
      tick();
      reset = 1'b0;

      // 1: reset state and plain array loads, incl. ignored low bits and aliasing
      load(32'h10);
      check("t1_wb_empty", 32'(wb_empty), 32'h1);
      check("t1_stall", 32'(MemStallM), 32'h0);
      check("t1_count", 32'(dut.fifo_count), 32'h0);
      check("t1_load_0x10", ReadDataM, 32'hA5A5_0004);
      load(32'h13);
      check("t1_load_low_bits", ReadDataM, 32'hA5A5_0004);
      load(32'h110);
      check("t1_load_alias", ReadDataM, 32'hA5A5_0004);

      // 2: forwarding of a pending store, then the drained value from the array
      store(32'h20, 32'hDEAD_BEEF);
      load(32'h20);
      check("t2_forward", ReadDataM, 32'hDEAD_BEEF);
      check("t2_not_empty", 32'(wb_empty), 32'h0);
      tick();
      tick();
      tick();
      check("t2_empty_before_lat", 32'(wb_empty), 32'h0);
      tick();
      check("t2_empty_after_lat", 32'(wb_empty), 32'h1);
      check("t2_array_read", ReadDataM, 32'hDEAD_BEEF);

      // 3: two stores to one word, youngest wins while both pending
      store(32'h40, 32'h0000_0001);
      store(32'h40, 32'h0000_0002);
      load(32'h40);
      check("t3_count_two", 32'(dut.fifo_count), 32'h2);
      check("t3_youngest", ReadDataM, 32'h0000_0002);
      load(32'h20);
      check("t3_other_word", ReadDataM, 32'hDEAD_BEEF);
      wait_empty("t3_drain", 40);
      load(32'h40);
      check("t3_array_final", ReadDataM, 32'h0000_0002);

      // 4: five back-to-back stores into a 4-entry buffer
      store(32'h80, 32'h0000_0101);
      store(32'h84, 32'h0000_0102);
      store(32'h88, 32'h0000_0103);
      store(32'h8C, 32'h0000_0104);
      MemWriteM  = 1'b1;
      ALUOutM    = 32'h90;
      WriteDataM = 32'h0000_0105;
      #1;
      check("t4_stall_full", 32'(MemStallM), 32'h1);
      check("t4_count_full", 32'(dut.fifo_count), 32'h4);
      tick();
      check("t4_stall_cleared", 32'(MemStallM), 32'h0);
      check("t4_count_after_drain", 32'(dut.fifo_count), 32'h3);
      tick();
      load(32'h90);
      check("t4_fifth_forward", ReadDataM, 32'h0000_0105);
      check("t4_count_refilled", 32'(dut.fifo_count), 32'h4);

      // 5: held store while a drain completes in the same cycle
      MemWriteM  = 1'b1;
      ALUOutM    = 32'h94;
      WriteDataM = 32'h0000_0106;
      #1;
      check("t5_stall_a", 32'(MemStallM), 32'h1);
      tick();
      check("t5_stall_during_drain", 32'(MemStallM), 32'h1);
      tick();
      check("t5_stall_released", 32'(MemStallM), 32'h0);
      check("t5_count_dropped", 32'(dut.fifo_count), 32'h3);
      tick();
      MemWriteM = 1'b0;
      #1;
      check("t5_count_stays_4", 32'(dut.fifo_count), 32'h4);
      check("t5_no_stall", 32'(MemStallM), 32'h0);
      wait_empty("t45_drain", 80);
      for (int i = 0; i < 6; i++) begin
         load(32'h80 + 32'(4 * i));
         check($sformatf("t45_array_%0d", i), ReadDataM, 32'h0000_0101 + 32'(i));
      end

      // 6: reset on the final latency cycle with three entries pending
      store(32'h60, 32'h0000_BAD0);
      store(32'h64, 32'h0000_BAD1);
      store(32'h68, 32'h0000_BAD2);
      check("t6_count_three", 32'(dut.fifo_count), 32'h3);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      load(32'h60);
      check("t6_wb_empty", 32'(wb_empty), 32'h1);
      check("t6_count", 32'(dut.fifo_count), 32'h0);
      check("t6_state_idle", 32'(dut.state), 32'h0);
      check("t6_array_kept", ReadDataM, 32'h3333_3333);
      MemWriteM  = 1'b1;
      ALUOutM    = 32'h70;
      WriteDataM = 32'h0000_7070;
      #1;
      check("t6_stall_after_reset", 32'(MemStallM), 32'h0);
      tick();
      load(32'h70);
      check("t6_store_after_reset", ReadDataM, 32'h0000_7070);
      wait_empty("t6_drain", 40);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
